rs_issue_queue: RTL and testbench
=================================

# rs_issue_queue

Reservation-station array that sits directly downstream of the scheduler in the dispatch path:
- Accepts one scheduler-built entry per cycle into the station slot the scheduler selected.
- Captures operand values broadcast on the two CDBs.
- Selects one fully-ready entry per cycle and hands it to the execute stage through a registered output with a valid/ready handshake.
- Exports the per-slot busy vector the scheduler uses to pick a free station.

## Interface
Parameters:
- RS_SIZE, 8: number of station slots.
- TAG_W, 5: ROB tag width; tag 0 means "no dependency / value present".
- DATA_W, 32: operand and immediate width.
- CTRL_W, 16: opaque control-bit bundle width, carried unmodified.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  synchronous squash of every entry and of the output register.
- disp_valid  in  1  dispatch request this cycle.
- disp_id  in  $clog2(RS_SIZE)  target slot.
- disp_tag  in  TAG_W  ROB tag of the instruction.
- disp_ctrl  in  CTRL_W  control bits.
- disp_tag1, disp_tag2  in  TAG_W  source producer tags (0 = ready).
- disp_val1, disp_val2  in  DATA_W  source values, valid when the matching tag is 0.
- disp_imm  in  DATA_W  immediate.
- disp_err  out  1  pulse: dispatch targeted a busy slot and was dropped.
- cdb1_tag, cdb2_tag  in  TAG_W  broadcast tags (0 = no broadcast).
- cdb1_val, cdb2_val  in  DATA_W  broadcast values.
- busy  out  RS_SIZE  per-slot occupancy.
- full  out  1  all slots busy.
- iss_valid  out  1  output register holds an issued entry.
- iss_ready  in  1  execute accepts the entry this cycle.
- iss_tag, iss_ctrl, iss_val1, iss_val2, iss_imm  out  entry fields of the output register.

## Operation
- Slot state: busy, tag, ctrl, tag1/val1, tag2/val2, imm.
- Dispatch: if disp_valid and !busy[disp_id], the slot is written and busy is set. If the slot is busy, the write is dropped and disp_err is asserted for that cycle.
- Wakeup: for each busy slot and each operand with tagN≠0, a match on cdb1_tag loads valN from cdb1_val and clears tagN. A match on cdb2_tag does the same from cdb2_val; cdb1 wins if both match.
- The same wakeup applies to the fields being dispatched in the same cycle, so a broadcast concurrent with dispatch is never lost.
- Ready slot: busy && tag1==0 && tag2==0.
- Select: lowest-index ready slot.
- Output register loads when (!iss_valid || iss_ready). On load, the selected slot's busy is cleared at the same edge, and iss_valid is set if a slot was selected, otherwise cleared.
- If iss_valid && !iss_ready, the output register holds all fields and no slot is freed.
- A slot freed by issue may be re-dispatched starting the next cycle. A dispatch to that slot in the freeing cycle sees busy=1 and is dropped.
- flush: all busy bits and iss_valid are cleared at the edge. Any dispatch in that cycle is discarded without disp_err.
- Tag compares use TAG_W bits. Tag 0 never matches a broadcast.

## Timing
- Reset values: busy=0, full=0, iss_valid=0, disp_err=0, all iss_* fields=0, all slot fields=0.
- Reset asserted mid-operation clears everything asynchronously. The first dispatch is accepted at the first edge after deassertion.
- Dispatch with ready operands at edge E: slot visible E+1; iss_valid at E+2 if the output register is free.
- Wakeup latency without bypass: broadcast in cycle k is captured at the end of k; the slot is selectable in k+1; iss_valid in k+2.
- Throughput: one issue per cycle while iss_ready stays high.
- busy and full are registered and reflect the state after the last edge.
- disp_err is combinational from the current inputs and state.

## Configuration
- RS_WAKEUP_BYPASS_EN defined:
  - Readiness also counts operands whose tag matches a current CDB broadcast.
  - The forwarded CDB value goes straight into the output register.
  - Wakeup-to-iss_valid latency becomes 1 cycle (broadcast in k, iss_valid in k+1).
  - Dispatch-to-issue latency is unchanged.
- Undefined: readiness uses stored tags only, giving the 2-cycle wakeup path above.

## Test plan
- Reset, then dispatch slot 0 (tag 3, tag1=tag2=0, val1=5, val2=7) with iss_ready=1 → iss_valid=1 two cycles later with iss_tag=3, val1=5, val2=7; busy returns to 0.
- Dispatch slot 2 with tag1=4; broadcast cdb2_tag=4, val=0x99 three cycles later → iss_val1=0x99, iss_valid 2 cycles after the broadcast (1 cycle with RS_WAKEUP_BYPASS_EN).
- cdb1_tag=cdb2_tag=6 with different values on a slot waiting on 6 → cdb1 value captured.
- Fill all 8 slots with ready entries and hold iss_ready=0 → full=1 and iss_valid held stable. Then iss_ready=1 for 8 cycles → tags issued in slot order 0..7.
- Dispatch to a busy slot → disp_err=1 for one cycle and slot contents unchanged.
- flush with 4 busy slots and iss_valid=1 → next cycle busy=0 and iss_valid=0. Assert reset mid-stall → all outputs 0 immediately.

Source files
------------

// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - reservation-station array with CDB wakeup, lowest-index select and registered issue port
// Optional feature macro: RS_WAKEUP_BYPASS_EN (forward current CDB broadcasts into select and the issue register)
module rs_issue_queue #(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 16,
    localparam int IDX_W  = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               disp_valid,
    input  logic [IDX_W-1:0]   disp_id,
    input  logic [TAG_W-1:0]   disp_tag,
    input  logic [CTRL_W-1:0]  disp_ctrl,
    input  logic [TAG_W-1:0]   disp_tag1,
    input  logic [TAG_W-1:0]   disp_tag2,
    input  logic [DATA_W-1:0]  disp_val1,
    input  logic [DATA_W-1:0]  disp_val2,
    input  logic [DATA_W-1:0]  disp_imm,
    output logic               disp_err,
    input  logic [TAG_W-1:0]   cdb1_tag,
    input  logic [TAG_W-1:0]   cdb2_tag,
    input  logic [DATA_W-1:0]  cdb1_val,
    input  logic [DATA_W-1:0]  cdb2_val,
    output logic [RS_SIZE-1:0] busy,
    output logic               full,
    output logic               iss_valid,
    input  logic               iss_ready,
    output logic [TAG_W-1:0]   iss_tag,
    output logic [CTRL_W-1:0]  iss_ctrl,
    output logic [DATA_W-1:0]  iss_val1,
    output logic [DATA_W-1:0]  iss_val2,
    output logic [DATA_W-1:0]  iss_imm
);
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } opnd_t;

    logic [RS_SIZE-1:0] busy_q;
    logic [TAG_W-1:0]   tag_q  [RS_SIZE];
    logic [CTRL_W-1:0]  ctrl_q [RS_SIZE];
    opnd_t              op1_q  [RS_SIZE];
    opnd_t              op2_q  [RS_SIZE];
    logic [DATA_W-1:0]  imm_q  [RS_SIZE];

    opnd_t              op1_w  [RS_SIZE];
    opnd_t              op2_w  [RS_SIZE];
    opnd_t              disp_op1_w;
    opnd_t              disp_op2_w;
    logic [RS_SIZE-1:0] ready;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               issue_ld;
    logic               disp_ok;

    // cdb1 has priority when both buses carry the awaited tag; tag 0 never matches
    function automatic opnd_t wake(input opnd_t op,
                                   input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v1,
                                   input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] v2);
        opnd_t r;
        r = op;
        if (op.tag != '0 && op.tag == t1) begin
            r.tag = '0;
            r.val = v1;
        end else if (op.tag != '0 && op.tag == t2) begin
            r.tag = '0;
            r.val = v2;
        end
        return r;
    endfunction

    always_comb begin
        disp_op1_w = wake(opnd_t'({disp_tag1, disp_val1}), cdb1_tag, cdb1_val, cdb2_tag, cdb2_val);
        disp_op2_w = wake(opnd_t'({disp_tag2, disp_val2}), cdb1_tag, cdb1_val, cdb2_tag, cdb2_val);
        ready      = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            op1_w[i] = wake(op1_q[i], cdb1_tag, cdb1_val, cdb2_tag, cdb2_val);
            op2_w[i] = wake(op2_q[i], cdb1_tag, cdb1_val, cdb2_tag, cdb2_val);
`ifdef RS_WAKEUP_BYPASS_EN
            ready[i] = busy_q[i] && op1_w[i].tag == '0 && op2_w[i].tag == '0;
`else
            ready[i] = busy_q[i] && op1_q[i].tag == '0 && op2_q[i].tag == '0;
`endif
        end
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_ld = !iss_valid || iss_ready;
    assign disp_ok  = disp_valid && !busy_q[disp_id] && !flush;
    assign disp_err = disp_valid && busy_q[disp_id] && !flush;
    assign busy     = busy_q;
    assign full     = &busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q    <= '0;
            iss_valid <= 1'b0;
            iss_tag   <= '0;
            iss_ctrl  <= '0;
            iss_val1  <= '0;
            iss_val2  <= '0;
            iss_imm   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                tag_q[i]  <= '0;
                ctrl_q[i] <= '0;
                op1_q[i]  <= '0;
                op2_q[i]  <= '0;
                imm_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    op1_q[i] <= op1_w[i];
                    op2_q[i] <= op2_w[i];
                end
            end
            if (flush) begin
                busy_q    <= '0;
                iss_valid <= 1'b0;
            end else begin
                if (issue_ld) begin
                    iss_valid <= sel_found;
                    if (sel_found) begin
                        busy_q[sel_idx] <= 1'b0;
                        iss_tag         <= tag_q[sel_idx];
                        iss_ctrl        <= ctrl_q[sel_idx];
                        iss_val1        <= op1_w[sel_idx].val;
                        iss_val2        <= op2_w[sel_idx].val;
                        iss_imm         <= imm_q[sel_idx];
                    end
                end
                // a slot freed by issue this edge was still busy, so it cannot also be the dispatch target
                if (disp_ok) begin
                    busy_q[disp_id] <= 1'b1;
                    tag_q[disp_id]  <= disp_tag;
                    ctrl_q[disp_id] <= disp_ctrl;
                    op1_q[disp_id]  <= disp_op1_w;
                    op2_q[disp_id]  <= disp_op2_w;
                    imm_q[disp_id]  <= disp_imm;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_issue_queue.sv
// tb/tb_rs_issue_queue.sv - directed and random checks of rs_issue_queue against a slot-array reference model
module tb_rs_issue_queue;
    localparam int N  = 8;
    localparam int TW = 5;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset, flush, disp_valid, iss_ready;
    logic [2:0]    disp_id;
    logic [TW-1:0] disp_tag, disp_tag1, disp_tag2, cdb1_tag, cdb2_tag;
    logic [CW-1:0] disp_ctrl;
    logic [DW-1:0] disp_val1, disp_val2, disp_imm, cdb1_val, cdb2_val;
    logic          disp_err, full, iss_valid;
    logic [N-1:0]  busy;
    logic [TW-1:0] iss_tag;
    logic [CW-1:0] iss_ctrl;
    logic [DW-1:0] iss_val1, iss_val2, iss_imm;

    int errors = 0;
    int checks = 0;

    logic [N-1:0]  m_busy;
    logic [TW-1:0] m_tag [N];
    logic [TW-1:0] m_t1  [N];
    logic [TW-1:0] m_t2  [N];
    logic [CW-1:0] m_ctrl[N];
    logic [DW-1:0] m_v1  [N];
    logic [DW-1:0] m_v2  [N];
    logic [DW-1:0] m_imm [N];
    logic          m_iv;
    logic [TW-1:0] m_itag;
    logic [CW-1:0] m_ictrl;
    logic [DW-1:0] m_iv1, m_iv2, m_iimm;

    int got[$];
    int exp_order[9];

    rs_issue_queue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_id(disp_id), .disp_tag(disp_tag), .disp_ctrl(disp_ctrl),
        .disp_tag1(disp_tag1), .disp_tag2(disp_tag2), .disp_val1(disp_val1), .disp_val2(disp_val2),
        .disp_imm(disp_imm), .disp_err(disp_err),
        .cdb1_tag(cdb1_tag), .cdb2_tag(cdb2_tag), .cdb1_val(cdb1_val), .cdb2_val(cdb2_val),
        .busy(busy), .full(full), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_tag(iss_tag), .iss_ctrl(iss_ctrl), .iss_val1(iss_val1), .iss_val2(iss_val2), .iss_imm(iss_imm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic hit(input logic [TW-1:0] t);
        return (t != 0) && (t == cdb1_tag || t == cdb2_tag);
    endfunction

    function automatic logic [DW-1:0] res_val(input logic [TW-1:0] t, input logic [DW-1:0] v);
        if (t != 0 && t == cdb1_tag) return cdb1_val;
        if (t != 0 && t == cdb2_tag) return cdb2_val;
        return v;
    endfunction

    function automatic logic [TW-1:0] res_tag(input logic [TW-1:0] t);
        return hit(t) ? '0 : t;
    endfunction

    function automatic logic op_ready(input logic [TW-1:0] t);
`ifdef RS_WAKEUP_BYPASS_EN
        return t == 0 || hit(t);
`else
        return t == 0;
`endif
    endfunction

    task automatic model_reset();
        m_busy = '0; m_iv = 0; m_itag = '0; m_ictrl = '0; m_iv1 = '0; m_iv2 = '0; m_iimm = '0;
        for (int i = 0; i < N; i++) begin
            m_tag[i] = '0; m_t1[i] = '0; m_t2[i] = '0; m_ctrl[i] = '0;
            m_v1[i] = '0; m_v2[i] = '0; m_imm[i] = '0;
        end
    endtask

    task automatic model_edge();
        int   sel;
        logic ld, acc;
        acc = disp_valid && !m_busy[disp_id] && !flush;
        ld  = !m_iv || iss_ready;
        sel = -1;
        for (int i = 0; i < N; i++)
            if (sel < 0 && m_busy[i] && op_ready(m_t1[i]) && op_ready(m_t2[i])) sel = i;
        for (int i = 0; i < N; i++) begin
            if (m_busy[i]) begin
                m_v1[i] = res_val(m_t1[i], m_v1[i]); m_t1[i] = res_tag(m_t1[i]);
                m_v2[i] = res_val(m_t2[i], m_v2[i]); m_t2[i] = res_tag(m_t2[i]);
            end
        end
        if (flush) begin
            m_busy = '0;
            m_iv   = 0;
        end else begin
            if (ld) begin
                m_iv = (sel >= 0);
                if (sel >= 0) begin
                    m_itag = m_tag[sel]; m_ictrl = m_ctrl[sel];
                    m_iv1 = m_v1[sel]; m_iv2 = m_v2[sel]; m_iimm = m_imm[sel];
                    m_busy[sel] = 0;
                end
            end
            if (acc) begin
                m_busy[disp_id] = 1; m_tag[disp_id] = disp_tag; m_ctrl[disp_id] = disp_ctrl;
                m_v1[disp_id] = res_val(disp_tag1, disp_val1); m_t1[disp_id] = res_tag(disp_tag1);
                m_v2[disp_id] = res_val(disp_tag2, disp_val2); m_t2[disp_id] = res_tag(disp_tag2);
                m_imm[disp_id] = disp_imm;
            end
        end
    endtask

    task automatic check_state();
        chk("busy", 64'(busy), 64'(m_busy));
        chk("full", 64'(full), 64'(&m_busy));
        chk("iss_valid", 64'(iss_valid), 64'(m_iv));
        if (m_iv) begin
            chk("iss_tag", 64'(iss_tag), 64'(m_itag));
            chk("iss_ctrl", 64'(iss_ctrl), 64'(m_ictrl));
            chk("iss_val1", 64'(iss_val1), 64'(m_iv1));
            chk("iss_val2", 64'(iss_val2), 64'(m_iv2));
            chk("iss_imm", 64'(iss_imm), 64'(m_iimm));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("disp_err", 64'(disp_err), 64'(disp_valid && m_busy[disp_id] && !flush));
        model_edge();
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle();
        disp_valid = 0; flush = 0; cdb1_tag = '0; cdb2_tag = '0;
    endtask

    task automatic set_disp(input int id, input int tag, input int t1, input logic [DW-1:0] v1,
                            input int t2, input logic [DW-1:0] v2);
        disp_valid = 1; disp_id = 3'(id); disp_tag = TW'(tag); disp_ctrl = CW'(16'h1000 + tag);
        disp_tag1 = TW'(t1); disp_val1 = v1; disp_tag2 = TW'(t2); disp_val2 = v2;
        disp_imm = DW'(32'hA000 + tag);
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        model_reset();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_iss_valid", 64'(iss_valid), 64'(0));
        chk("rst_disp_err", 64'(disp_err), 64'(0));
        chk("rst_iss_fields", 64'({iss_tag, iss_ctrl} | 64'(iss_val1 | iss_val2 | iss_imm)), 64'(0));
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 0; iss_ready = 1; disp_id = '0; disp_tag = '0; disp_ctrl = '0;
        disp_tag1 = '0; disp_tag2 = '0; disp_val1 = '0; disp_val2 = '0; disp_imm = '0;
        cdb1_val = '0; cdb2_val = '0;
        idle();
        do_reset();

        // ready dispatch to slot 0 issues two edges later
        set_disp(0, 3, 0, 5, 0, 7);
        tick();
        chk("t1_busy", 64'(busy), 64'(8'h01));
        chk("t1_not_yet", 64'(iss_valid), 64'(0));
        idle(); tick();
        chk("t1_valid", 64'(iss_valid), 64'(1));
        chk("t1_tag", 64'(iss_tag), 64'(3));
        chk("t1_vals", 64'({iss_val1, iss_val2}), {32'd5, 32'd7});
        chk("t1_busy_clr", 64'(busy), 64'(0));

        // cdb2 wakeup of a waiting operand
        set_disp(2, 9, 4, 0, 0, 32'h22);
        tick(); idle(); tick(); tick(); tick();
        cdb2_tag = 4; cdb2_val = 32'h99;
        tick(); idle();
`ifndef RS_WAKEUP_BYPASS_EN
        chk("t2_no_early", 64'(iss_valid), 64'(0));
        tick();
`endif
        chk("t2_valid", 64'(iss_valid), 64'(1));
        chk("t2_val1", 64'(iss_val1), 64'(32'h99));

        // both CDBs carry the awaited tag: cdb1 wins
        set_disp(5, 10, 6, 0, 0, 32'h33);
        tick();
        idle(); cdb1_tag = 6; cdb1_val = 32'h111; cdb2_tag = 6; cdb2_val = 32'h222;
        tick(); idle();
`ifndef RS_WAKEUP_BYPASS_EN
        tick();
`endif
        chk("t3_tag", 64'(iss_tag), 64'(10));
        chk("t3_val1", 64'(iss_val1), 64'(32'h111));
        tick(); tick();

        // fill every slot while execute stalls, then drain in slot order
        iss_ready = 0;
        for (int k = 0; k < N; k++) begin
            set_disp(k, 16 + k, 0, 32'(k), 0, 32'(k * 2));
            tick();
        end
        set_disp(0, 31, 0, 32'h31, 0, 32'h62);
        tick(); idle();
        chk("t4_full", 64'(full), 64'(1));
        chk("t4_held_tag", 64'(iss_tag), 64'(16));
        tick(); tick();
        chk("t4_still_held", 64'({iss_valid, iss_tag}), 64'({1'b1, 5'd16}));
        exp_order = '{16, 31, 17, 18, 19, 20, 21, 22, 23};
        iss_ready = 1;
        for (int k = 0; k < 9; k++) begin
            if (iss_valid) got.push_back(int'(iss_tag));
            tick();
        end
        chk("t4_count", 64'(got.size()), 64'(9));
        for (int k = 0; k < got.size() && k < 9; k++) chk("t4_order", 64'(got[k]), 64'(exp_order[k]));

        // dispatch to a busy slot is dropped and flagged
        set_disp(3, 7, 12, 0, 0, 32'h55);
        tick();
        set_disp(3, 8, 0, 32'hdead, 0, 32'hbeef);
        #1;
        chk("t5_err", 64'(disp_err), 64'(1));
        tick(); idle();
        #1;
        chk("t5_err_clear", 64'(disp_err), 64'(0));
        cdb1_tag = 12; cdb1_val = 32'habc;
        tick(); idle();
`ifndef RS_WAKEUP_BYPASS_EN
        tick();
`endif
        chk("t5_kept_tag", 64'(iss_tag), 64'(7));
        chk("t5_kept_vals", 64'({iss_val1, iss_val2}), {32'habc, 32'h55});
        tick();

        // flush squashes slots and the output register, without disp_err
        iss_ready = 0;
        for (int k = 0; k < 5; k++) begin
            set_disp(k, 1 + k, 0, 32'(k), 0, 32'(k));
            tick();
        end
        idle();
        chk("t6_busy4", 64'(busy), 64'(8'h1E));
        chk("t6_valid", 64'(iss_valid), 64'(1));
        set_disp(6, 20, 0, 0, 0, 0);
        flush = 1;
        #1;
        chk("t6_flush_no_err", 64'(disp_err), 64'(0));
        tick(); idle();
        chk("t6_busy0", 64'(busy), 64'(0));
        chk("t6_valid0", 64'(iss_valid), 64'(0));

        // asynchronous reset while the issue port is stalled
        set_disp(0, 11, 0, 1, 0, 2); tick();
        set_disp(1, 12, 0, 3, 0, 4); tick();
        idle(); tick();
        chk("t7_stalled", 64'(iss_valid), 64'(1));
        #2;
        do_reset();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            disp_valid = 1'($urandom_range(0, 1));
            disp_id    = 3'($urandom_range(0, 7));
            disp_tag   = TW'($urandom_range(1, 31));
            disp_ctrl  = CW'($urandom);
            disp_tag1  = ($urandom_range(0, 1) == 0) ? TW'($urandom_range(1, 7)) : '0;
            disp_tag2  = ($urandom_range(0, 2) == 0) ? TW'($urandom_range(1, 7)) : '0;
            disp_val1  = $urandom;
            disp_val2  = $urandom;
            disp_imm   = $urandom;
            cdb1_tag   = ($urandom_range(0, 2) == 0) ? TW'($urandom_range(1, 7)) : '0;
            cdb2_tag   = ($urandom_range(0, 2) == 0) ? TW'($urandom_range(1, 7)) : '0;
            cdb1_val   = $urandom;
            cdb2_val   = $urandom;
            iss_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 49) == 0);
            tick();
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
